seq_16_divider: RTL and testbench

SEQ_16_DIVIDER -- requirements
Module: seq_16_divider

---
 rtl/seq_16_divider.sv | 92 +++++++++
 tb/tb_seq_16_divider.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_16_divider.sv
// seq_16_divider: restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Define DIV_SIGNED_EN for two's-complement operands (adds one sign fix-up cycle).
module seq_16_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef DIV_SIGNED_EN
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] quo, rem, dvs, a_mag, b_mag;
  logic [WIDTH:0] trial, diff;
  logic [CW-1:0] cnt;
  logic dbz, zero;
  assign zero = divisor == '0;
  // quo doubles as the dividend shift register: its MSB feeds the trial, the new quotient bit enters at the LSB
  assign trial = {rem, quo[WIDTH-1]};
  assign diff = trial - {1'b0, dvs};
`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;
  assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_mag = divisor[WIDTH-1] ? -divisor : divisor;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
`endif
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign quotient = quo;
  assign remainder = rem;
  assign div_by_zero = dbz;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE && in_valid) state_n = zero ? DONE : CALC;
    else if (state == CALC && cnt == LAST) state_n = DONE;
    else if (state == DONE && out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
      dbz <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      cnt <= '0;
      dbz <= zero;
      dvs <= b_mag;
      quo <= zero ? '1 : a_mag;
      rem <= zero ? dividend : '0;
`ifdef DIV_SIGNED_EN
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
`endif
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
`ifdef DIV_SIGNED_EN
      if (cnt == LAST) begin
        quo <= neg_q ? -quo : quo;
        rem <= neg_r ? -rem : rem;
      end else begin
        quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
        rem <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
      end
`else
      quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
      rem <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
`endif
    end
  end
endmodule

// File: tb/tb_seq_16_divider.sv
// tb_seq_16_divider: directed vectors with a scoreboard queue and a decoupled negedge monitor.
module tb_seq_16_divider;
`ifdef DIV_SIGNED_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [15:0] dividend = 0, divisor = 0;
  logic in_ready, out_valid, div_by_zero;
  logic [15:0] quotient, remainder;
  typedef struct {logic [15:0] q; logic [15:0] r; logic z; int lat;} exp_t;
  exp_t sb[$];
  exp_t e;
  int vectors = 0, miscompares = 0, ncyc = 0, acc = 0;
  bit busy = 0, post_hs = 0, prev_ov = 0, prev_rdy = 0;
  logic [15:0] pq, pr;
  logic pz;

  seq_16_divider #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      busy = 0;
      post_hs = 0;
      prev_ov = 0;
    end else begin
      if (busy) chk("in_ready_low", in_ready, 0);
      if (post_hs) chk("in_ready_after_hs", in_ready, 1);
      post_hs = 0;
      if (out_valid && prev_ov && !prev_rdy) begin
        chk("stall_q", quotient, pq);
        chk("stall_r", remainder, pr);
        chk("stall_z", div_by_zero, pz);
      end
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_out_valid at %0t", $time);
        end else chk("latency", ncyc - acc, sb[0].lat);
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.z);
        busy = 0;
        post_hs = 1;
      end
      if (in_valid && in_ready) begin
        busy = 1;
        acc = ncyc;
      end
      prev_ov = out_valid;
    end
    prev_rdy = out_ready;
    pq = quotient;
    pr = remainder;
    pz = div_by_zero;
  end

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                     input logic [15:0] r, input logic z, input bit push);
    int i;
    @(posedge clk); #1;
    dividend = a;
    divisor = b;
    in_valid = 1;
    @(negedge clk);
    for (i = 0; i < 200 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready stayed 0");
    end else if (push) sb.push_back('{q, r, z, z ? 1 : LAT});
    @(posedge clk); #1;
    in_valid = 0;
    dividend = 16'($urandom);
    divisor = 16'($urandom);
  endtask

  task automatic drain;
    int i;
    for (i = 0; i < 200 && (sb.size() > 0 || busy); i++) @(negedge clk);
    if (sb.size() > 0 || busy) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(posedge clk); #1;
    rst = 0;
    run(16'd100, 16'd7, 16'd14, 16'd2, 0, 1);
    drain();
    run(16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1, 1);
    drain();
    run(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 0, 1);
    run(16'd5, 16'd9, 16'd0, 16'd5, 0, 1);
    drain();
    run(16'd12345, 16'd123, 16'd100, 16'd45, 0, 1);
    run(16'd7, 16'd7, 16'd1, 16'd0, 0, 1);
    run(16'd0, 16'd5, 16'd0, 16'd0, 0, 1);
    run(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 0, 1);
`ifdef DIV_SIGNED_EN
    run(16'h8000, 16'd3, 16'hD556, 16'hFFFE, 0, 1);
    run(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 0, 1);
    run(16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 0, 1);
    run(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 0, 1);
    run(16'hFFF9, 16'd0, 16'hFFFF, 16'hFFF9, 1, 1);
`else
    run(16'h8000, 16'd3, 16'h2AAA, 16'd2, 0, 1);
    run(16'd1, 16'hFFFF, 16'd0, 16'd1, 0, 1);
`endif
    drain();
    out_ready = 0;
    run(16'd1000, 16'd10, 16'd100, 16'd0, 0, 1);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    repeat (5) @(posedge clk);
    #1 out_ready = 1;
    drain();
    run(16'd1000, 16'd3, 16'd0, 16'd0, 0, 0);
    repeat (8) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    repeat (25) @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    run(16'd50, 16'd5, 16'd10, 16'd0, 0, 1);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
